// File: rtl/countdown_pkg.sv
// Shared types and helpers for the countdown timer family.
package countdown_pkg;

  typedef enum logic [0:0] {RUN = 1'b0, DONE = 1'b1} cd_state_t;

  localparam logic CD_ONESHOT = 1'b0;
  localparam logic CD_RELOAD  = 1'b1;

  // Ceil(log2(v)), but never below 1 so a divide-by-1 still gets a legal register width.
  function automatic int cd_clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between the countdown timer and its game/quiz controller.
interface countdown_timer_if #(parameter int WIDTH = 4);
  logic             En;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             reload_md;
  logic [WIDTH-1:0] st_cd;
  logic             t_up;
  logic             running;

  modport master (output En, load, load_val, reload_md, input st_cd, t_up, running);
  modport slave  (input En, load, load_val, reload_md, output st_cd, t_up, running);
endinterface

// File: rtl/countdown_timer_prescaler.sv
// Enable divider: one tick every PRESCALE enabled cycles, cleared by load.
// Present only when COUNTDOWN_PRESCALER_EN is defined.
`ifdef COUNTDOWN_PRESCALER_EN
module cd_prescaler
  import countdown_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic CP,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int PW = cd_clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Phase freezes while disabled so counting resumes exactly where it stopped.
  always_ff @(posedge CP or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (tick) cnt <= '0;
    else if (en)   cnt <= cnt + PW'(1);
  end
endmodule
`endif

// File: rtl/countdown_timer.sv
// Parametrised down-counter with load, optional prescaler and one-shot/auto-reload.
// Optional prescaler: COUNTDOWN_PRESCALER_EN (otherwise every enabled cycle is a step).
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int INIT_VAL = 9,
  parameter int PRESCALE = 1
) (
  input  logic               CP,
  input  logic               rst,
  countdown_timer_if.slave   bus
);
  localparam logic [WIDTH-1:0] INIT    = WIDTH'(INIT_VAL);
  localparam logic [0:0]       ST_RUN  = 1'(RUN);
  localparam logic [0:0]       ST_DONE = 1'(DONE);

  logic [0:0]       state;
  logic [WIDTH-1:0] st_cd_q;
  logic [WIDTH-1:0] reload_q;
  logic             t_up_q;
  logic             tick;

`ifdef COUNTDOWN_PRESCALER_EN
  cd_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .CP   (CP),
    .rst  (rst),
    .en   (bus.En),
    .clr  (bus.load),
    .tick (tick)
  );
`else
  logic unused_prescale;
  assign unused_prescale = (PRESCALE != 0);
  assign tick = bus.En;
`endif

  // load beats tick; in RUN t_up defaults low so reload-mode expiry is a single-cycle pulse.
  always_ff @(posedge CP or posedge rst) begin
    if (rst) begin
      st_cd_q  <= INIT;
      reload_q <= INIT;
      state    <= (INIT != '0) ? ST_RUN : ST_DONE;
      t_up_q   <= (INIT == '0);
    end else if (bus.load) begin
      st_cd_q  <= bus.load_val;
      reload_q <= bus.load_val;
      if (bus.load_val == '0 && bus.reload_md == CD_ONESHOT) begin
        state  <= ST_DONE;
        t_up_q <= 1'b1;
      end else begin
        state  <= ST_RUN;
        t_up_q <= 1'b0;
      end
    end else if (state == ST_RUN) begin
      t_up_q <= 1'b0;
      if (tick) begin
        if (st_cd_q > WIDTH'(1)) begin
          st_cd_q <= st_cd_q - WIDTH'(1);
        end else if (st_cd_q == WIDTH'(1)) begin
          st_cd_q <= '0;
          t_up_q  <= 1'b1;
          if (bus.reload_md == CD_ONESHOT) state <= ST_DONE;
        end else if (bus.reload_md == CD_RELOAD) begin
          st_cd_q <= reload_q;
        end else begin
          // Mode flipped to one-shot while parked at 0: settle in DONE rather than reload.
          state  <= ST_DONE;
          t_up_q <= 1'b1;
        end
      end
    end
  end

  assign bus.st_cd   = st_cd_q;
  assign bus.t_up    = t_up_q;
  assign bus.running = (state == ST_RUN);

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Parametrised countdown timer, next generation of the 3-bit `Countdown` block. It adds configurable width, a load port, a clock prescaler, and one-shot or auto-reload modes. It drives a down-counting display value and an expiry flag for the game/quiz controllers. It sits between the board clock divider and the display/buzzer logic.

## Interface
- `WIDTH`, 4: counter width in bits, 2..16.
- `INIT_VAL`, 4'd9: count and reload value after reset, < 2^WIDTH.
- `PRESCALE`, 1: enabled clock cycles per count step, 1..65535.
- `CP` in 1: clock, rising-edge active.
- `rst` in 1: asynchronous, active-high reset.
- `En` in 1: run enable, level-sensitive. 0 freezes count and prescaler.
- `load` in 1: one-cycle synchronous load strobe.
- `load_val` in WIDTH: value captured on `load` into count and reload register.
- `reload_md` in 1: 0 = one-shot, 1 = auto-reload.
- `st_cd` out WIDTH: current count, registered.
- `t_up` out 1: expiry indication, registered.
- `running` out 1: high in state RUN.

## Operation
- Reset (async) values:
  - `st_cd` = INIT_VAL, reload register = INIT_VAL, prescaler = 0.
  - State = RUN if INIT_VAL ≠ 0, else DONE.
  - `t_up` = 0 and `running` = 1 if INIT_VAL ≠ 0, else `t_up` = 1 and `running` = 0.
- `tick` (internal) = `En` && prescaler == PRESCALE−1. On tick the prescaler wraps to 0; otherwise it increments while `En` = 1.
- State RUN, on tick:
  - `st_cd` > 1: decrement.
  - `st_cd` == 1: `st_cd` ← 0. In one-shot mode → DONE. In reload mode → stay in RUN, `t_up` pulses.
  - `st_cd` == 0 (reload mode only): `st_cd` ← reload register. Reload period = reload+1 ticks.
- State DONE (one-shot only): `st_cd` holds 0, `t_up` = 1 (level), `running` = 0. Leave only by `load` or reset.
- In DONE, a `reload_md` 0→1 change has no effect until the next `load`.
- `load`:
  - Next edge: `st_cd` ← `load_val`, reload register ← `load_val`, prescaler ← 0, `t_up` ← 0.
  - State → RUN if `load_val` ≠ 0.
  - State → DONE if `load_val` == 0 in one-shot mode, with `t_up` = 1 the next cycle.
  - In reload mode a load of 0 gives state RUN with a 1-tick period.
- Priority: `rst` > `load` > tick. `load` coincident with a tick discards the tick.
- `En` is ignored for `load`: loads occur regardless of `En`.
- No arithmetic wraps below 0. The count never underflows.

## Timing
- All outputs registered. No combinational path from inputs to outputs.
- Count changes on the CP edge that samples the tick condition. With PRESCALE = P, a step occurs every P enabled cycles. The first step after load is P enabled cycles after the load edge.
- Reload-mode `t_up`: exactly one cycle wide, asserted the cycle `st_cd` first reads 0.
- One-shot `t_up`: level from the cycle `st_cd` reads 0 until the cycle after `load`.
- `running` updates on the same edge as the state change.
- Reset asserted mid-count: outputs take reset values immediately, without waiting for CP. Release is synchronous to the next CP edge.

## Configuration
- `COUNTDOWN_PRESCALER_EN` defined:
  - Prescaler counter of width clog2(PRESCALE) is present, behaving as above.
- Not defined:
  - No prescaler logic. `tick` = `En`. PRESCALE is ignored.
  - Every enabled cycle is a step. All other behaviour is identical.

## Structure
- Shared package `countdown_pkg`:
  - State enum `cd_state_t` {RUN, DONE}.
  - Mode constants `CD_ONESHOT` = 1'b0, `CD_RELOAD` = 1'b1.
  - Function `cd_clog2` for prescaler sizing.
- One sub-module, `cd_prescaler`: a parameterised enable divider producing `tick` from `En`, with synchronous clear on `load`. It is compiled only under `COUNTDOWN_PRESCALER_EN`.
- Counter and FSM stay in `countdown_timer`.

## Test plan
All cases use WIDTH=4, INIT_VAL=5, PRESCALE=2, macro defined, 20 ns clock.
- Reset then `En`=1, one-shot: `st_cd` 5→4→3→2→1→0, stepping every 2 cycles. `t_up`=1 and `running`=0 from 0 onward, held for 20 cycles.
- `En` dropped at `st_cd`=3 for 7 cycles: `st_cd` and prescaler hold. Counting resumes at the same prescaler phase.
- Reload mode, `load` `load_val`=2: sequence 2,1,0,2,1,0. `t_up` is a single-cycle pulse on each 0 entry, every 6 cycles.
- `load` `load_val`=0 in one-shot: next cycle `st_cd`=0, `t_up`=1, `running`=0.
- `load` `load_val`=7 on the same cycle as a tick: `st_cd`=7 next cycle, no decrement. The first step to 6 occurs 2 cycles later.
- `rst` pulsed asynchronously mid-count at `st_cd`=2: `st_cd`=5, `t_up`=0 before the next CP edge.
